// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back stage.
package wb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 3;
    localparam int unsigned WB_SEL_W   = 2;

    // Write-back source select
    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_IN  = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_t;

    // Output-port buffer occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ob_state_t;

endpackage

// File: rtl/out_port_buf.sv
// One-entry output-port buffer with valid/ready handshake on the consumer side.
module out_port_buf
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] loadData,
    input  logic              outReady,
    output logic [DATA_W-1:0] outPort,
    output logic              outValid,
    output logic              full
);

    ob_state_t         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // State and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load always wins (drain+reload when FULL), otherwise drain on ready
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    data_d  = loadData;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    data_d  = loadData;
                    state_d = FULL;
                end else if (outReady) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign outPort  = data_q;
    assign full     = (state_q == FULL);
    assign outValid = full;

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back source mux, register-file write port and output port.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memValid,
    input  logic                memRegWrite,
    input  logic [WB_SEL_W-1:0] memWbSel,
    input  logic [REG_AW-1:0]   memRdst,
    input  logic [DATA_W-1:0]   memAluResult,
    input  logic [DATA_W-1:0]   memReadData,
    input  logic [DATA_W-1:0]   memInData,
    input  logic                memOutEn,
    input  logic                outReady,
    output logic                regWrite,
    output logic [REG_AW-1:0]   Rdst,
    output logic [DATA_W-1:0]   writeData,
    output logic [DATA_W-1:0]   outPort,
    output logic                outValid,
    output logic                wbStall
);

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    wb_sel_t           wbsel_q,    wbsel_d;
    logic [REG_AW-1:0] rdst_q,     rdst_d;
    logic [DATA_W-1:0] alu_q,      alu_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [DATA_W-1:0] indata_q,   indata_d;
    logic              outen_q,    outen_d;

    logic              buf_full;
    logic              retire;
    logic              buf_load;
    logic [DATA_W-1:0] sel_val;

    // WB register: capture from MEM unless the stage is stalled
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wbsel_d    = wbsel_q;
        rdst_d     = rdst_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        indata_d   = indata_q;
        outen_d    = outen_q;
        if (!wbStall) begin
            valid_d    = memValid;
            regwrite_d = memRegWrite;
            wbsel_d    = wb_sel_t'(memWbSel);
            rdst_d     = memRdst;
            alu_d      = memAluResult;
            rdata_d    = memReadData;
            indata_d   = memInData;
            outen_d    = memOutEn;
        end
    end

    // WB register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wbsel_q    <= WB_ALU;
            rdst_q     <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            indata_q   <= '0;
            outen_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wbsel_q    <= wbsel_d;
            rdst_q     <= rdst_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            indata_q   <= indata_d;
            outen_q    <= outen_d;
        end
    end

    // Write-back source mux; the reserved code falls back to the ALU result
    always_comb begin
        sel_val = alu_q;
        case (wbsel_q)
            WB_ALU:  sel_val = alu_q;
            WB_MEM:  sel_val = rdata_q;
            WB_IN:   sel_val = indata_q;
            WB_RSV:  sel_val = alu_q;
            default: sel_val = alu_q;
        endcase
    end

    // An OUT can only block when the buffer is occupied and the consumer is not taking it
    assign wbStall   = valid_q & outen_q & buf_full & ~outReady;
    assign retire    = valid_q & ~wbStall;
    assign buf_load  = retire & outen_q;

    assign regWrite  = retire & regwrite_q;
    assign Rdst      = rdst_q;
    assign writeData = sel_val;

    out_port_buf #(
        .DATA_W (DATA_W)
    ) u_out_port_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .loadData (sel_val),
        .outReady (outReady),
        .outPort  (outPort),
        .outValid (outValid),
        .full     (buf_full)
    );

endmodule
